// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the i2s_rx and i2s_tx blocks.
package i2s_pkg;

    localparam int DEF_WIDTH = 16;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

endpackage

// File: rtl/i2s_rx_if.sv
// I2S receive bundle: serial stream in, parallel sample pair out.
interface i2s_rx_if
    import i2s_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             sclk;
    logic             lrclk;
    logic             sdata;
    logic [WIDTH-1:0] left_chan;
    logic [WIDTH-1:0] right_chan;
    logic             valid;
    logic             locked;

    modport master (
        output sclk, lrclk, sdata,
        input  left_chan, right_chan, valid, locked
    );

    modport slave (
        input  sclk, lrclk, sdata,
        output left_chan, right_chan, valid, locked
    );
endinterface

// File: rtl/i2s_rx_sync.sv
// Multi-flop synchroniser for the I2S pins plus sclk rising-edge detect.
module i2s_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sclk,
    input  logic i_lrclk,
    input  logic i_sdata,
    output logic o_lrclk,
    output logic o_sdata,
    output logic o_sclk_rise
);
    logic [STAGES-1:0] r_sclk;
    logic [STAGES-1:0] r_lrclk;
    logic [STAGES-1:0] r_sdata;
    logic              r_sclk_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk   <= '0;
            r_lrclk  <= '0;
            r_sdata  <= '0;
            r_sclk_d <= 1'b0;
        end else begin
            r_sclk   <= {r_sclk[STAGES-2:0], i_sclk};
            r_lrclk  <= {r_lrclk[STAGES-2:0], i_lrclk};
            r_sdata  <= {r_sdata[STAGES-2:0], i_sdata};
            r_sclk_d <= r_sclk[STAGES-1];
        end
    end

    assign o_lrclk     = r_lrclk[STAGES-1];
    assign o_sdata     = r_sdata[STAGES-1];
    assign o_sclk_rise = r_sclk[STAGES-1] & ~r_sclk_d;
endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: MSB-first deserialiser with left/right pair commit.
// Optional stream-lock supervision is enabled with I2S_RX_LOCK_EN.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic     clk,
    input  logic     rst,
    i2s_rx_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] TOP = {1'b1, {(WIDTH-1){1'b0}}};

    if (SYNC_STAGES < 2 || TIMEOUT < 2) begin : g_bad_param
        $error("i2s_rx: SYNC_STAGES and TIMEOUT must be at least 2");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_left_hold;
    logic [WIDTH-1:0] r_left_chan;
    logic [WIDTH-1:0] r_right_chan;
    logic [CW-1:0]    r_cnt;
    logic             r_lr_prev;
    logic             r_valid;

    logic             w_rise;
    logic             w_lr;
    logic             w_sd;
    logic             w_room;
    logic             w_edge;
    logic             w_tmo;
    logic             w_locked;
    logic [WIDTH-1:0] w_word;

    i2s_rx_sync #(
        .STAGES      (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .rst         (rst),
        .i_sclk      (bus.sclk),
        .i_lrclk     (bus.lrclk),
        .i_sdata     (bus.sdata),
        .o_lrclk     (w_lr),
        .o_sdata     (w_sd),
        .o_sclk_rise (w_rise)
    );

    // Current word including this edge's bit; bits past WIDTH are dropped.
    assign w_room = (r_cnt < CW'(WIDTH));
    assign w_word = (w_room && w_sd) ? (r_shift | (TOP >> r_cnt)) : r_shift;
    assign w_edge = w_rise && (w_lr != r_lr_prev);

`ifdef I2S_RX_LOCK_EN
    localparam int TW = $clog2(TIMEOUT);

    logic [TW-1:0] r_tmo;
    logic [1:0]    r_frames;
    logic          r_locked;
    logic          w_commit;

    assign w_tmo    = (r_tmo == TW'(TIMEOUT - 1));
    assign w_locked = r_locked;
    assign w_commit = w_edge && (r_state == RIGHT) && !w_tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo    <= '0;
            r_frames <= '0;
            r_locked <= 1'b0;
        end else begin
            if (w_rise)
                r_tmo <= '0;
            else if (!w_tmo)
                r_tmo <= r_tmo + 1'b1;

            if (w_tmo) begin
                r_locked <= 1'b0;
                r_frames <= '0;
            end else if (w_commit && !r_locked) begin
                if (r_frames == 2'd1)
                    r_locked <= 1'b1;
                r_frames <= r_frames + 1'b1;
            end
        end
    end
`else
    assign w_tmo    = 1'b0;
    assign w_locked = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_lr_prev    <= 1'b0;
            r_left_hold  <= '0;
            r_left_chan  <= '0;
            r_right_chan <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_tmo) begin
                r_state <= IDLE;
                r_shift <= '0;
                r_cnt   <= '0;
            end else if (w_rise) begin
                r_lr_prev <= w_lr;
                if (w_edge) begin
                    r_shift <= '0;
                    r_cnt   <= '0;
                    unique case (r_state)
                        IDLE: begin
                            // Align on the start of a left word only.
                            if (r_lr_prev == CH_RIGHT)
                                r_state <= LEFT;
                        end
                        LEFT: begin
                            r_left_hold <= w_word;
                            r_state     <= RIGHT;
                        end
                        RIGHT: begin
                            r_left_chan  <= r_left_hold;
                            r_right_chan <= w_word;
                            r_valid      <= w_locked;
                            r_state      <= LEFT;
                        end
                        default: r_state <= IDLE;
                    endcase
                end else begin
                    r_shift <= w_word;
                    if (w_room)
                        r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.left_chan  = r_left_chan;
    assign bus.right_chan = r_right_chan;
    assign bus.valid      = r_valid;
    assign bus.locked     = w_locked;
endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S serial audio receiver; the receive-side counterpart of i2s_tx.
- Samples an external I2S stream (sclk, lrclk, sdata) that is asynchronous to the core clock.
- Deserialises MSB-first words and presents a left/right sample pair with a one-cycle valid strobe.
- Intended for line-in capture from the audio codec (e.g. MAX9850) into the Minimig audio mixer path, clocked from clk_114.

Parameters:
- WIDTH, 16, bits per captured sample; extra bits on the wire are truncated, missing bits are zero-padded.
- SYNC_STAGES, 2, synchroniser flop depth for sclk/lrclk/sdata; minimum 2.
- TIMEOUT, 1024, clk cycles without an sclk rising edge before lock is lost (used only with I2S_RX_LOCK_EN).

Ports:
- clk  in  1  core clock; must be at least 4x the sclk frequency.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  I2S bit clock (external, asynchronous).
- lrclk  in  1  word select; 0 = left, 1 = right.
- sdata  in  1  serial data, MSB first, I2S one-bit delay.
- left_chan  out  WIDTH  last complete left sample.
- right_chan  out  WIDTH  last complete right sample.
- valid  out  1  one-clk pulse; left_chan/right_chan updated together.
- locked  out  1  stream healthy (see Optional Feature).

Behaviour:
- Reset (async, rst=1): left_chan=0, right_chan=0, valid=0, locked=0 (1 without macro), shift register=0, bit count=0, state=IDLE, all synchroniser flops=0.
- Synchronisation: sclk, lrclk and sdata each pass through SYNC_STAGES flops. sclk_rise = sync_sclk & ~sclk_d. All protocol logic acts only in cycles where sclk_rise=1.
- lr_prev register: holds lrclk as sampled at the previous sclk_rise.
- Word-select transition (at sclk_rise, lrclk_s != lr_prev):
  - The bit sampled on this rise is the LSB of the previous word (I2S delay). It is written if bit count < WIDTH.
  - The word is then committed according to lr_prev, and bit count and the shift register are cleared.
- No transition: if bit count < WIDTH, write sdata_s at bit position WIDTH-1-count and increment count; otherwise ignore the bit (truncation). Count saturates at WIDTH.
- Short words (fewer bits than WIDTH) are left-aligned; the LSBs remain 0.
- States:
  - IDLE: after reset or loss of lock. Ignore bits until the first lrclk 1->0 transition, then go to LEFT. The partial word is discarded and nothing is committed.
  - LEFT: on the 0->1 transition, commit the word to the left hold register and go to RIGHT.
  - RIGHT: on the 1->0 transition, copy the left hold register to left_chan and the right word to right_chan, pulse valid, and go to LEFT.
- valid is asserted in the clk cycle after the commit edge, for exactly one cycle. Outputs are stable until the next commit.
- Outputs only update once a full left+right pair has been received after IDLE.
- A glitch with lrclk toggling twice within one word is treated as a normal transition; the data will be garbage, but no hang or overflow occurs.
- sclk stopping mid-word: the state is held indefinitely (no macro) or times out (macro).
- rst asserted mid-word: everything is cleared immediately; the next capture starts from IDLE.

Optional Feature:
- Macro: I2S_RX_LOCK_EN.
- With the macro:
  - A timeout counter of clog2(TIMEOUT) bits clears on each sclk_rise.
  - If it reaches TIMEOUT-1: locked<=0, state<=IDLE, and the partial data is discarded.
  - locked<=1 after two consecutive complete frames committed following IDLE.
  - valid is suppressed while locked=0, but the outputs still update.
- Without the macro: locked is tied to 1, there is no timeout counter, and valid is never suppressed.

Decomposition:
- Shared package i2s_pkg:
  - State typedef (IDLE/LEFT/RIGHT).
  - Channel constants CH_LEFT=0 and CH_RIGHT=1, shared with i2s_tx.
  - Default WIDTH constant.
- One sub-module, i2s_rx_sync: a parameterised SYNC_STAGES synchroniser for the three inputs, plus the sclk rising-edge detect.
- The shift/commit FSM stays in i2s_rx.

Test Plan:
- Standard frame: clk=114 MHz, sclk=3.5 MHz, WIDTH=16, send L=16'hA5C3, R=16'h1234 for two frames. Expected: one valid pulse per frame after the first full pair; left_chan=16'hA5C3, right_chan=16'h1234.
- Long words: 24-bit words L=24'h89ABCD, R=24'h012345. Expected: left_chan=16'h89AB, right_chan=16'h0123 (truncated).
- Short words: 12-bit words L=12'hFFF, R=12'h801. Expected: left_chan=16'hFFF0, right_chan=16'h8010.
- Startup mid-stream: start the stream at bit 7 of a right word. Expected: no valid until a complete L+R pair arrives; the first valid carries the correct pair, never the partial word.
- Reset mid-word: assert rst during left bit 9. Expected: outputs 0 and valid 0 immediately; the next good frame is received correctly after IDLE resync.
- Loss of clock (I2S_RX_LOCK_EN, TIMEOUT=1024):
  - Stop sclk. Expected: locked falls 1024 clks after the last edge.
  - Restart sclk. Expected: locked=1 after two full frames; valid is suppressed while unlocked.
